// File: rtl/nabp_image_ram_arbiter.sv
// nabp_image_ram_arbiter: round-robin image RAM arbiter, PE writes vs host reads.
// Optional per-burst beat limit: define NABP_ARB_BURST_LIMIT_EN.
module nabp_image_ram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
`ifdef NABP_ARB_BURST_LIMIT_EN
   ,
   parameter int BURST_MAX = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pe_req,
   input  logic              pe_last,
   input  logic [ADDR_W-1:0] pe_addr,
   input  logic [DATA_W-1:0] pe_wdata,
   output logic              pe_gnt,
   input  logic              hs_req,
   input  logic [ADDR_W-1:0] hs_addr,
   output logic              hs_gnt,
   output logic              hs_rd_valid,
   output logic [DATA_W-1:0] hs_rd_data,
   output logic              ir_we,
   output logic              ir_re,
   output logic [ADDR_W-1:0] ir_addr,
   output logic [DATA_W-1:0] ir_wdata,
   input  logic [DATA_W-1:0] ir_rdata,
   output logic [1:0]        owner
);

   typedef enum logic [1:0] {
      IDLE,
      PE_BURST,
      HS_BURST,
      TURN
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_last_hs;
   logic              w_pe_gnt;
   logic              w_hs_gnt;
   logic              w_pe_end;
   logic              w_hs_end;
   logic              w_at_lim;
   logic              r_we;
   logic              r_re;
   logic              r_re_d;
   logic              r_rd_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rd_data;

   assign w_pe_gnt = !reset && (r_state == PE_BURST) && pe_req;
   assign w_hs_gnt = !reset && (r_state == HS_BURST) && hs_req;

`ifdef NABP_ARB_BURST_LIMIT_EN
   localparam int CNT_W = $clog2(BURST_MAX + 1);
   logic [CNT_W-1:0] r_cnt;

   assign w_at_lim = (r_cnt == CNT_W'(BURST_MAX - 1));

   // Beat counter: cleared while idle, saturates at BURST_MAX
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state == IDLE) begin
         r_cnt <= '0;
      end else if ((w_pe_gnt || w_hs_gnt) &&
                   (r_cnt != CNT_W'(BURST_MAX))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   assign w_at_lim = 1'b0;
`endif

   assign w_pe_end = (r_state == PE_BURST) &&
                     (!pe_req || pe_last || w_at_lim);
   assign w_hs_end = (r_state == HS_BURST) &&
                     (!hs_req || w_at_lim);

   // Next-state: round-robin pick in IDLE, one TURN cycle after every burst
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (pe_req && (!hs_req || r_last_hs)) begin
               w_next = PE_BURST;
            end else if (hs_req) begin
               w_next = HS_BURST;
            end
         end
         PE_BURST: if (w_pe_end) w_next = TURN;
         HS_BURST: if (w_hs_end) w_next = TURN;
         TURN:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // State register and last-served pointer (host after reset)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_last_hs <= 1'b1;
      end else begin
         r_state <= w_next;
         if (w_pe_end) begin
            r_last_hs <= 1'b0;
         end else if (w_hs_end) begin
            r_last_hs <= 1'b1;
         end
      end
   end

   // RAM command stage and two-stage read return; reset drops all in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we       <= 1'b0;
         r_re       <= 1'b0;
         r_re_d     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd_data  <= '0;
      end else begin
         r_we       <= w_pe_gnt;
         r_re       <= w_hs_gnt;
         r_re_d     <= r_re;
         r_rd_valid <= r_re_d;
         if (w_pe_gnt) begin
            r_addr  <= pe_addr;
            r_wdata <= pe_wdata;
         end else if (w_hs_gnt) begin
            r_addr <= hs_addr;
         end
         if (r_re_d) begin
            r_rd_data <= ir_rdata;
         end
      end
   end

   assign pe_gnt      = w_pe_gnt;
   assign hs_gnt      = w_hs_gnt;
   assign ir_we       = r_we;
   assign ir_re       = r_re;
   assign ir_addr     = r_addr;
   assign ir_wdata    = r_wdata;
   assign hs_rd_valid = r_rd_valid;
   assign hs_rd_data  = r_rd_data;
   assign owner       = reset                  ? 2'b00 :
                        (r_state == PE_BURST) ? 2'b01 :
                        (r_state == HS_BURST) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_nabp_image_ram_arbiter.sv
// tb_nabp_image_ram_arbiter: directed vector table plus randomized
// traffic against a transaction-level model of the arbiter.
module tb_nabp_image_ram_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
`ifdef NABP_ARB_BURST_LIMIT_EN
   localparam bit LIM_EN = 1'b1;
`else
   localparam bit LIM_EN = 1'b0;
`endif
   localparam int BMAX = 16;
   localparam int NCYC = 3000;

   logic          clk = 1'b0;
   logic          reset;
   logic          pe_req, pe_last, pe_gnt;
   logic [AW-1:0] pe_addr;
   logic [DW-1:0] pe_wdata;
   logic          hs_req, hs_gnt;
   logic [AW-1:0] hs_addr;
   logic          hs_rd_valid;
   logic [DW-1:0] hs_rd_data;
   logic          ir_we, ir_re;
   logic [AW-1:0] ir_addr;
   logic [DW-1:0] ir_wdata;
   logic [DW-1:0] ir_rdata;
   logic [1:0]    owner;

   always #5 clk = ~clk;

   nabp_image_ram_arbiter dut (
      .clk(clk), .reset(reset),
      .pe_req(pe_req), .pe_last(pe_last),
      .pe_addr(pe_addr), .pe_wdata(pe_wdata),
      .pe_gnt(pe_gnt),
      .hs_req(hs_req), .hs_addr(hs_addr), .hs_gnt(hs_gnt),
      .hs_rd_valid(hs_rd_valid), .hs_rd_data(hs_rd_data),
      .ir_we(ir_we), .ir_re(ir_re), .ir_addr(ir_addr),
      .ir_wdata(ir_wdata), .ir_rdata(ir_rdata),
      .owner(owner)
   );

   // Image RAM stand-in: one-cycle read latency, content = addr ^ 0x5A7A
   always @(posedge clk) ir_rdata <= ir_addr ^ 16'h5A7A;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      bit rst, pr, pl, hr;
      logic [15:0] pa, pd, ha;
      bit gp, gh;
      logic [1:0] own;
      bit we, re, vl;
      logic [15:0] ea, ed, rd;
      bit z;
   } vec_t;

   vec_t v[19];

   // Transaction-level reference model
   int  m_own;
   bit  m_turn;
   bit  m_pe_prio;
   int  m_cnt;
   int  cyc;
   bit  e_we[0:8191];
   bit  e_re[0:8191];
   bit  e_vl[0:8191];
   bit [15:0] e_wa[0:8191];
   bit [15:0] e_wd[0:8191];
   bit [15:0] e_ra[0:8191];
   bit [15:0] e_rd[0:8191];
   bit  a_pg, a_hg;

   task automatic step(input bit rst, pr, pl, hr,
                       input logic [15:0] pa, pd, ha);
      bit gp, gh;
      reset = rst; pe_req = pr; pe_last = pl; hs_req = hr;
      pe_addr = pa; pe_wdata = pd; hs_addr = ha;
      #3;
      gp = !rst && m_own == 1 && pr;
      gh = !rst && m_own == 2 && hr;
      a_pg = pe_gnt; a_hg = hs_gnt;
      chk("pe_gnt", pe_gnt, gp);
      chk("hs_gnt", hs_gnt, gh);
      chk("owner", owner, rst ? 2'b00 : 2'(m_own));
      chk("ir_we", ir_we, e_we[cyc]);
      chk("ir_re", ir_re, e_re[cyc]);
      chk("hs_rd_valid", hs_rd_valid, e_vl[cyc]);
      if (e_we[cyc]) begin
         chk("wr_addr", ir_addr, e_wa[cyc]);
         chk("wr_data", ir_wdata, e_wd[cyc]);
      end
      if (e_re[cyc]) chk("rd_addr", ir_addr, e_ra[cyc]);
      if (e_vl[cyc]) chk("rd_data", hs_rd_data, e_rd[cyc]);
      if (gp) begin
         e_we[cyc+1] = 1; e_wa[cyc+1] = pa; e_wd[cyc+1] = pd;
      end
      if (gh) begin
         e_re[cyc+1] = 1; e_ra[cyc+1] = ha;
         e_vl[cyc+3] = 1; e_rd[cyc+3] = ha ^ 16'h5A7A;
      end
      if (rst) begin
         e_vl[cyc+1] = 0; e_vl[cyc+2] = 0;
      end
      if (rst) begin
         m_own = 0; m_turn = 0; m_pe_prio = 1; m_cnt = 0;
      end else if (m_turn) begin
         m_turn = 0;
      end else if (m_own == 0) begin
         if (pr && (!hr || m_pe_prio)) begin
            m_own = 1; m_cnt = 0;
         end else if (hr) begin
            m_own = 2; m_cnt = 0;
         end
      end else if (m_own == 1) begin
         if (pr) m_cnt++;
         if (!pr || pl || (LIM_EN && m_cnt == BMAX)) begin
            m_own = 0; m_turn = 1; m_pe_prio = 0;
         end
      end else begin
         if (hr) m_cnt++;
         if (!hr || (LIM_EN && m_cnt == BMAX)) begin
            m_own = 0; m_turn = 1; m_pe_prio = 1;
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      v[0]  = '{1,0,0,0,'h00,'h00,'h00, 0,0,0, 0,0,0,'h00,'h00,'h0000, 1};
      v[1]  = '{0,1,0,1,'h10,'hA0,'h00, 0,0,0, 0,0,0,'h00,'h00,'h0000, 0};
      v[2]  = '{0,1,0,1,'h10,'hA0,'h00, 1,0,1, 0,0,0,'h00,'h00,'h0000, 0};
      v[3]  = '{0,1,0,1,'h11,'hA1,'h00, 1,0,1, 1,0,0,'h10,'hA0,'h0000, 0};
      v[4]  = '{0,1,0,1,'h12,'hA2,'h00, 1,0,1, 1,0,0,'h11,'hA1,'h0000, 0};
      v[5]  = '{0,1,1,1,'h13,'hA3,'h00, 1,0,1, 1,0,0,'h12,'hA2,'h0000, 0};
      v[6]  = '{0,0,0,1,'h00,'h00,'h20, 0,0,0, 1,0,0,'h13,'hA3,'h0000, 0};
      v[7]  = '{0,0,0,1,'h00,'h00,'h20, 0,0,0, 0,0,0,'h00,'h00,'h0000, 0};
      v[8]  = '{0,0,0,1,'h00,'h00,'h20, 0,1,2, 0,0,0,'h00,'h00,'h0000, 0};
      v[9]  = '{0,0,0,0,'h00,'h00,'h00, 0,0,2, 0,1,0,'h20,'h00,'h0000, 0};
      v[10] = '{0,0,0,0,'h00,'h00,'h00, 0,0,0, 0,0,0,'h00,'h00,'h0000, 0};
      v[11] = '{0,0,0,0,'h00,'h00,'h00, 0,0,0, 0,0,1,'h00,'h00,'h5A5A, 0};
      v[12] = '{0,1,0,1,'h30,'hB0,'h00, 0,0,0, 0,0,0,'h00,'h00,'h0000, 0};
      v[13] = '{0,1,0,1,'h30,'hB0,'h00, 1,0,1, 0,0,0,'h00,'h00,'h0000, 0};
      v[14] = '{1,1,0,1,'h31,'hB1,'h00, 0,0,0, 1,0,0,'h30,'hB0,'h0000, 0};
      v[15] = '{0,1,0,1,'h31,'hB1,'h00, 0,0,0, 0,0,0,'h00,'h00,'h0000, 1};
      v[16] = '{0,1,0,1,'h31,'hB1,'h00, 1,0,1, 0,0,0,'h00,'h00,'h0000, 0};
      v[17] = '{0,0,0,0,'h00,'h00,'h00, 0,0,1, 1,0,0,'h31,'hB1,'h0000, 0};
      v[18] = '{0,0,0,0,'h00,'h00,'h00, 0,0,0, 0,0,0,'h00,'h00,'h0000, 0};

      reset = 1; pe_req = 0; pe_last = 0; hs_req = 0;
      pe_addr = 0; pe_wdata = 0; hs_addr = 0;
      @(posedge clk); #1;

      for (int i = 0; i < 19; i++) begin
         reset = v[i].rst; pe_req = v[i].pr; pe_last = v[i].pl;
         hs_req = v[i].hr; pe_addr = v[i].pa; pe_wdata = v[i].pd;
         hs_addr = v[i].ha;
         #3;
         chk($sformatf("v%0d pe_gnt", i), pe_gnt, v[i].gp);
         chk($sformatf("v%0d hs_gnt", i), hs_gnt, v[i].gh);
         chk($sformatf("v%0d owner", i), owner, v[i].own);
         chk($sformatf("v%0d ir_we", i), ir_we, v[i].we);
         chk($sformatf("v%0d ir_re", i), ir_re, v[i].re);
         chk($sformatf("v%0d hs_rd_valid", i), hs_rd_valid, v[i].vl);
         if (v[i].we) begin
            chk($sformatf("v%0d wr_addr", i), ir_addr, v[i].ea);
            chk($sformatf("v%0d wr_data", i), ir_wdata, v[i].ed);
         end
         if (v[i].re) chk($sformatf("v%0d rd_addr", i), ir_addr, v[i].ea);
         if (v[i].vl) chk($sformatf("v%0d rd_data", i), hs_rd_data, v[i].rd);
         if (v[i].z) begin
            chk($sformatf("v%0d ir_addr zero", i), ir_addr, 0);
            chk($sformatf("v%0d ir_wdata zero", i), ir_wdata, 0);
            chk($sformatf("v%0d hs_rd_data zero", i), hs_rd_data, 0);
         end
         @(posedge clk); #1;
      end

      cyc = 0;
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < NCYC; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) < 6,
              16'($urandom), 16'($urandom), 16'($urandom));
      end

`ifdef NABP_ARB_BURST_LIMIT_EN
      begin
         int npe;
         bit hs_seen;
         bit pe_after;
         npe = 0; hs_seen = 0; pe_after = 0;
         step(1, 0, 0, 0, 0, 0, 0);
         for (int i = 0; i < 45; i++) begin
            step(0, 1, 0, i < 30, 16'(i), 16'(i + 100), 16'(i + 200));
            if (a_hg) hs_seen = 1;
            if (a_pg && !hs_seen) npe++;
            if (a_pg && hs_seen) pe_after = 1;
         end
         chk("limit pe beats", npe, BMAX);
         chk("limit host granted", hs_seen, 1);
         chk("limit pe regrant", pe_after, 1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
